// File: rtl/PSL_pkg.sv
// Shared constants and types for the p-bit weight interface.
// h_bit_width / j_bit_width set the field widths seen by every p-bit.
package PSL_pkg;

  localparam int unsigned h_bit_width = 8;
  localparam int unsigned j_bit_width = 6;

  // Words per p-bit: one h followed by six J values
  localparam int unsigned NUM_SLOTS = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_t;

endpackage

// File: rtl/loader_addr_counter.sv
// Slot/p-bit address counter for the weight loader.
// Slots 0..NUM_SLOTS-1 wrap to 0 and step the p-bit index.
module loader_addr_counter
  import PSL_pkg::*;
#(
  parameter int unsigned NUM_PBITS = 16,
  parameter int unsigned PIDX_W    = (NUM_PBITS > 1) ? $clog2(NUM_PBITS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [PIDX_W-1:0] pbit_idx,
  output logic [2:0]        slot_idx,
  output logic              is_final
);

  localparam logic [2:0]        LAST_SLOT = 3'(NUM_SLOTS - 1);
  localparam logic [PIDX_W-1:0] LAST_PBIT = PIDX_W'(NUM_PBITS - 1);

  logic [PIDX_W-1:0] pbit_q, pbit_d;
  logic [2:0]        slot_q, slot_d;

  // Next counter value: clear has priority over advance
  always_comb begin
    pbit_d = pbit_q;
    slot_d = slot_q;
    if (clear) begin
      pbit_d = '0;
      slot_d = '0;
    end else if (advance) begin
      if (slot_q == LAST_SLOT) begin
        slot_d = '0;
        pbit_d = (pbit_q == LAST_PBIT) ? '0 : pbit_q + PIDX_W'(1);
      end else begin
        slot_d = slot_q + 3'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pbit_q <= '0;
      slot_q <= '0;
    end else begin
      pbit_q <= pbit_d;
      slot_q <= slot_d;
    end
  end

  assign pbit_idx = pbit_q;
  assign slot_idx = slot_q;
  assign is_final = (pbit_q == LAST_PBIT) && (slot_q == LAST_SLOT);

endmodule

// File: rtl/pbit_weight_loader.sv
// Writer side of the p-bit weight interface: fills per-p-bit h/J
// registers from a valid/ready word stream and raises weight_load_DONE
// one cycle after the final register write.
// Optional macro LOADER_READBACK_EN adds a registered rd_addr/rd_data port.
module pbit_weight_loader
  import PSL_pkg::*;
#(
  parameter int unsigned NUM_PBITS = 16,
  parameter int unsigned NUM_NEIGH = 6,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   load_start,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [WORD_W-1:0]                      wr_data,
  input  logic                                   wr_last,
  output logic [NUM_PBITS*h_bit_width-1:0]       h_flat,
  output logic [NUM_PBITS*NUM_NEIGH*j_bit_width-1:0] J_flat,
  output logic                                   weight_load_DONE,
  output logic                                   load_err
`ifdef LOADER_READBACK_EN
  ,
  input  logic [$clog2(NUM_PBITS*NUM_SLOTS)-1:0] rd_addr,
  output logic [WORD_W-1:0]                      rd_data
`endif
);

  localparam int unsigned HW        = h_bit_width;
  localparam int unsigned JW        = j_bit_width;
  localparam int unsigned PIDX_W    = (NUM_PBITS > 1) ? $clog2(NUM_PBITS) : 1;

  loader_state_t state_q, state_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [NUM_PBITS*HW-1:0]           h_flat_q, h_flat_d;
  logic [NUM_PBITS*NUM_NEIGH*JW-1:0] j_flat_q, j_flat_d;

  logic              cnt_clear, cnt_advance, wr_en;
  logic [PIDX_W-1:0] pbit_idx;
  logic [2:0]        slot_idx;
  logic              is_final;

  loader_addr_counter #(
    .NUM_PBITS (NUM_PBITS),
    .PIDX_W    (PIDX_W)
  ) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .advance  (cnt_advance),
    .pbit_idx (pbit_idx),
    .slot_idx (slot_idx),
    .is_final (is_final)
  );

  assign wr_ready = (state_q == LOAD);

  // Next-state, framing-error and DONE logic
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d   = LOAD;
          cnt_clear = 1'b1;
          err_d     = 1'b0;
        end
      end
      LOAD: begin
        if (load_start) begin
          cnt_clear = 1'b1;
        end else if (wr_valid) begin
          if (wr_last && !is_final) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (is_final) begin
              state_d = wr_last ? DONE : IDLE;
              err_d   = !wr_last;
            end else begin
              cnt_advance = 1'b1;
            end
          end
        end
      end
      DONE: begin
        // DONE is registered from the state, so it trails the last write by one cycle
        done_d = !load_start;
        if (load_start) begin
          state_d   = LOAD;
          cnt_clear = 1'b1;
          err_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Weight register write decode
  always_comb begin
    h_flat_d = h_flat_q;
    j_flat_d = j_flat_q;
    if (wr_en) begin
      if (slot_idx == 3'd0) begin
        h_flat_d[int'(pbit_idx)*HW +: HW] = wr_data[HW-1:0];
      end else begin
        j_flat_d[(int'(pbit_idx)*NUM_NEIGH + int'(slot_idx) - 1)*JW +: JW] = wr_data[JW-1:0];
      end
    end
  end

`ifdef LOADER_READBACK_EN
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  int unsigned       rd_a, rd_p, rd_s;

  // Readback decode: same address order as the load, sign-extended
  always_comb begin
    rd_data_d = '0;
    rd_a      = 32'(rd_addr);
    rd_p      = rd_a / NUM_SLOTS;
    rd_s      = rd_a % NUM_SLOTS;
    if (rd_a < NUM_PBITS*NUM_SLOTS) begin
      if (rd_s == 0) begin
        rd_data_d = WORD_W'($signed(h_flat_q[rd_p*HW +: HW]));
      end else begin
        rd_data_d = WORD_W'($signed(j_flat_q[(rd_p*NUM_NEIGH + rd_s - 1)*JW +: JW]));
      end
    end
  end

  assign rd_data = rd_data_q;
`endif

  // FSM and weight registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      h_flat_q <= '0;
      j_flat_q <= '0;
`ifdef LOADER_READBACK_EN
      rd_data_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      err_q    <= err_d;
      h_flat_q <= h_flat_d;
      j_flat_q <= j_flat_d;
`ifdef LOADER_READBACK_EN
      rd_data_q <= rd_data_d;
`endif
    end
  end

  assign h_flat           = h_flat_q;
  assign J_flat           = j_flat_q;
  assign weight_load_DONE = done_q;
  assign load_err         = err_q;

endmodule

// File: tb/tb_pbit_weight_loader.sv
// Scoreboard bench for pbit_weight_loader (NUM_PBITS=2).
// Define LOADER_READBACK_EN to also exercise the readback port.
module tb_pbit_weight_loader;

  localparam int NP = 2;
  localparam int NN = 6;
  localparam int WW = 8;
  localparam int HW = 8;
  localparam int JW = 6;
  localparam int NW = NP * 7;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  load_start = 1'b0;
  logic                  wr_valid = 1'b0;
  logic                  wr_last = 1'b0;
  logic [WW-1:0]         wr_data = '0;
  logic                  wr_ready;
  logic [NP*HW-1:0]      h_flat;
  logic [NP*NN*JW-1:0]   J_flat;
  logic                  weight_load_DONE;
  logic                  load_err;
`ifdef LOADER_READBACK_EN
  logic [3:0]            rd_addr = '0;
  logic [WW-1:0]         rd_data;
`endif

  pbit_weight_loader #(
    .NUM_PBITS (NP),
    .NUM_NEIGH (NN),
    .WORD_W    (WW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_start       (load_start),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_data          (wr_data),
    .wr_last          (wr_last),
    .h_flat           (h_flat),
    .J_flat           (J_flat),
    .weight_load_DONE (weight_load_DONE),
    .load_err         (load_err)
`ifdef LOADER_READBACK_EN
    ,
    .rd_addr          (rd_addr),
    .rd_data          (rd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: weights as plain integer arrays
  int exp_h [NP];
  int exp_j [NP*NN];
  int mdl_k = 0;

  typedef struct {
    string               tag;
    logic [NP*HW-1:0]    h;
    logic [NP*NN*JW-1:0] j;
    bit                  done;
    bit                  err;
  } snap_t;
  snap_t sbq[$];

  function automatic logic [NP*HW-1:0] pack_h();
    logic [NP*HW-1:0] v;
    for (int p = 0; p < NP; p++) v[p*HW +: HW] = HW'(exp_h[p]);
    return v;
  endfunction

  function automatic logic [NP*NN*JW-1:0] pack_j();
    logic [NP*NN*JW-1:0] v;
    for (int i = 0; i < NP*NN; i++) v[i*JW +: JW] = JW'(exp_j[i]);
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_snap(input string tag, input bit done, input bit err);
    snap_t s;
    s.tag  = tag;
    s.h    = pack_h();
    s.j    = pack_j();
    s.done = done;
    s.err  = err;
    sbq.push_back(s);
  endtask

  task automatic model_clear();
    for (int p = 0; p < NP; p++) exp_h[p] = 0;
    for (int i = 0; i < NP*NN; i++) exp_j[i] = 0;
    mdl_k = 0;
  endtask

  // Model of one accepted word, following the word-order and framing rules
  task automatic model_word(input int d, input bit last);
    int p, s;
    bit fin;
    p   = mdl_k / 7;
    s   = mdl_k % 7;
    fin = (mdl_k == NW - 1);
    if (last && !fin) begin
      push_snap("early_last", 1'b0, 1'b1);
    end else begin
      if (s == 0) exp_h[p] = d % 256;
      else        exp_j[p*NN + s - 1] = d % 64;
      if (fin) push_snap(last ? "load_done" : "missing_last", last, !last);
      else     mdl_k++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit with_valid);
    load_start = 1'b1;
    wr_valid   = with_valid;
    wr_data    = 8'h55;
    tick();
    load_start = 1'b0;
    wr_valid   = 1'b0;
    mdl_k      = 0;
    check("done_low_after_start", weight_load_DONE, 1'b0);
    check("err_low_after_start", load_err, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input bit last, input bit gap);
    check("ready_in_load", wr_ready, 1'b1);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    model_word(int'(d), last);
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (gap) tick();
  endtask

  task automatic load_full(input bit rnd, input bit gap);
    for (int k = 0; k < NW; k++)
      send(rnd ? 8'($urandom) : 8'(k + 1), k == NW - 1, gap);
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_h"}, 128'(h_flat), 128'(pack_h()));
    check({tag, "_j"}, 128'(J_flat), 128'(pack_j()));
  endtask

`ifdef LOADER_READBACK_EN
  task automatic check_rd(input int a);
    int e, p, s;
    rd_addr = 4'(a);
    tick();
    e = 0;
    if (a < NW) begin
      p = a / 7;
      s = a % 7;
      if (s == 0) e = exp_h[p];
      else begin
        e = exp_j[p*NN + s - 1];
        if (e >= 32) e = e - 64;
      end
    end
    check($sformatf("rd_data_addr%0d", a), 128'(rd_data), 128'(8'(e)));
  endtask
`endif

  // Monitor: compare registers whenever DONE or load_err rises
  task automatic pop_compare(input string ev);
    snap_t s;
    n_tests++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got event expected none", ev);
    end else begin
      s = sbq.pop_front();
      check({s.tag, "_h"}, 128'(h_flat), 128'(s.h));
      check({s.tag, "_j"}, 128'(J_flat), 128'(s.j));
      check({s.tag, "_done"}, 128'(weight_load_DONE), 128'(s.done));
      check({s.tag, "_err"}, 128'(load_err), 128'(s.err));
    end
  endtask

  initial begin
    int  cyc = 0;
    int  last_hs = -100;
    bit  prev_done = 1'b0;
    bit  prev_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_done = 1'b0;
        prev_err  = 1'b0;
      end else begin
        if (weight_load_DONE && !prev_done) begin
          check("done_latency", 128'(cyc), 128'(last_hs + 2));
          pop_compare("done");
        end
        if (load_err && !prev_err) pop_compare("err");
        prev_done = weight_load_DONE;
        prev_err  = load_err;
        if (wr_valid && wr_ready && !load_start) last_hs = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    repeat (2) tick();
    check("rst_h", 128'(h_flat), 128'(0));
    check("rst_j", 128'(J_flat), 128'(0));
    check("rst_done", weight_load_DONE, 1'b0);
    check("rst_err", load_err, 1'b0);
    check("rst_ready", wr_ready, 1'b0);
    rst_n = 1'b1;
    tick();

    // Counting load 0x01..0x0E
    start(1'b0);
    load_full(1'b0, 1'b0);
    settle();
    check_regs("count_load");
    check("count_done", weight_load_DONE, 1'b1);
    check("count_ready", wr_ready, 1'b0);
`ifdef LOADER_READBACK_EN
    check_rd(9);
    check_rd(0);
    check_rd(14);
    check_rd(15);
    for (int i = 0; i < 4; i++) check_rd(int'($urandom_range(0, 15)));
`endif

    // Random load with valid toggling every cycle
    start(1'b0);
    load_full(1'b1, 1'b1);
    settle();
    check_regs("gap_load");

    // wr_last on word 5
    start(1'b0);
    for (int k = 0; k < 4; k++) send(8'($urandom), 1'b0, 1'b0);
    send(8'($urandom), 1'b1, 1'b0);
    settle();
    check_regs("early_last");
    check("early_err", load_err, 1'b1);
    check("early_done", weight_load_DONE, 1'b0);
    check("early_idle", wr_ready, 1'b0);

    // Full load, then partial reload of three words
    start(1'b0);
    load_full(1'b1, 1'b0);
    settle();
    start(1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'hF1, 1'b0, 1'b0);
    send(8'hF2, 1'b0, 1'b0);
    check_regs("partial_reload");
    check("partial_done", weight_load_DONE, 1'b0);
    for (int k = 3; k < NW; k++) send(8'($urandom), k == NW - 1, 1'b0);
    settle();

    // Final word without wr_last
    start(1'b0);
    for (int k = 0; k < NW; k++) send(8'($urandom), 1'b0, 1'b0);
    settle();
    check("nolast_err", load_err, 1'b1);
    check("nolast_idle", wr_ready, 1'b0);

    // Restart mid-load with a word presented on the restart cycle
    start(1'b0);
    for (int k = 0; k < 3; k++) send(8'($urandom), 1'b0, 1'b0);
    start(1'b1);
    load_full(1'b1, 1'b0);
    settle();

    // Asynchronous reset while word 7 is presented
    start(1'b0);
    for (int k = 0; k < 6; k++) send(8'($urandom), 1'b0, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 8'($urandom);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("arst_h", 128'(h_flat), 128'(0));
    check("arst_j", 128'(J_flat), 128'(0));
    check("arst_done", weight_load_DONE, 1'b0);
    check("arst_err", load_err, 1'b0);
    check("arst_ready", wr_ready, 1'b0);
    wr_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    start(1'b1);
    load_full(1'b0, 1'b0);
    settle();
    check_regs("after_arst");

    settle();
    check("scoreboard_empty", 128'(sbq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
